// File: rtl/div_seq.sv
// rtl/div_seq.sv - Multi-cycle restoring divider and stall sequencer for MIPS DIV/DIVU.
// One quotient bit per cycle; results land in registered hi/lo for a single-cycle write window.
module div_seq #(
  parameter logic [7:0] DIV_OP  = 8'b00011010,
  parameter logic [7:0] DIVU_OP = 8'b00011011
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  alucontrol,
  input  logic        start,
  input  logic        annul,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        stall,
  output logic        result_valid,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ZERO = 2'd1,
    ON   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        neg_q_q, neg_q_d;
  logic        neg_r_q, neg_r_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dz_q, dz_d;

  logic        is_div;
  logic        signed_op;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem33;
  logic        fits;
  logic [31:0] rem_step;
  logic [31:0] quo_step;

  assign is_div    = start & ((alucontrol == DIV_OP) | (alucontrol == DIVU_OP));
  assign signed_op = (alucontrol == DIV_OP);
  assign a_mag     = (signed_op & a[31]) ? (32'd0 - a) : a;
  assign b_mag     = (signed_op & b[31]) ? (32'd0 - b) : b;

  // rem stays below the divisor, so a 32-bit wrapping subtract is exact whenever it fits
  assign rem33    = {rem_q, quo_q[31]};
  assign fits     = rem33 >= {1'b0, dvsr_q};
  assign rem_step = fits ? (rem33[31:0] - dvsr_q) : rem33[31:0];
  assign quo_step = {quo_q[30:0], fits};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dvsr_d       = dvsr_q;
    neg_q_d      = neg_q_q;
    neg_r_d      = neg_r_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    dz_d         = dz_q;
    stall        = 1'b0;
    result_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (!annul && is_div) begin
          stall = 1'b1;
          if (b == 32'd0) begin
            state_d = ZERO;
          end else begin
            dvsr_d  = b_mag;
            quo_d   = a_mag;
            rem_d   = 32'd0;
            cnt_d   = 5'd0;
            neg_q_d = signed_op & (a[31] ^ b[31]);
            neg_r_d = signed_op & a[31];
            state_d = ON;
          end
        end
      end
      ZERO: begin
        stall = 1'b1;
        if (annul) begin
          state_d = IDLE;
        end else begin
          hi_d    = 32'd0;
          lo_d    = 32'd0;
          dz_d    = 1'b1;
          state_d = DONE;
        end
      end
      ON: begin
        stall = 1'b1;
        if (annul) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_step;
          quo_d = quo_step;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            lo_d    = neg_q_q ? (32'd0 - quo_step) : quo_step;
            hi_d    = neg_r_q ? (32'd0 - rem_step) : rem_step;
            dz_d    = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        result_valid = ~annul;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvsr_q  <= 32'd0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - Directed self-checking bench for div_seq.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_div_seq;

  localparam logic [7:0] OP_DIV  = 8'b00011010;
  localparam logic [7:0] OP_DIVU = 8'b00011011;
  localparam logic [7:0] OP_ADD  = 8'b00100000;
  localparam logic [7:0] OP_NOP  = 8'b00000000;

  logic        clk;
  logic        resetn;
  logic [7:0]  alucontrol;
  logic        start;
  logic        annul;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall;
  logic        result_valid;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int compared   = 0;
  int mismatched = 0;

  div_seq #(.DIV_OP(OP_DIV), .DIVU_OP(OP_DIVU)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .alucontrol   (alucontrol),
    .start        (start),
    .annul        (annul),
    .a            (a),
    .b            (b),
    .stall        (stall),
    .result_valid (result_valid),
    .hi           (hi),
    .lo           (lo),
    .div_zero     (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered just after a rising edge; that cycle is cycle 0 of the operation.
  task automatic do_div(input string tag, input logic [7:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input int exp_lat, input logic [31:0] elo,
                        input logic [31:0] ehi, input logic edz);
    int cyc;
    int busy;
    alucontrol = op;
    a          = av;
    b          = bv;
    start      = 1'b1;
    @(negedge clk);
    check({tag, "_stall_c0"}, {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1;
    start      = 1'b0;
    alucontrol = OP_NOP;
    cyc  = 1;
    busy = 0;
    @(negedge clk);
    while (!result_valid && cyc < 40) begin
      if (stall) busy++;
      cyc++;
      @(negedge clk);
    end
    check({tag, "_latency"}, cyc, exp_lat);
    check({tag, "_stall_cycles"}, busy, exp_lat - 1);
    check({tag, "_lo"}, lo, elo);
    check({tag, "_hi"}, hi, ehi);
    check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, edz});
    check({tag, "_stall_end"}, {31'd0, stall}, 32'd0);
    @(negedge clk);
    check({tag, "_idle_rv"}, {31'd0, result_valid}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] last_lo;
    logic [31:0] last_hi;
    resetn     = 1'b0;
    alucontrol = OP_NOP;
    start      = 1'b0;
    annul      = 1'b0;
    a          = 32'd0;
    b          = 32'd0;
    #12;
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_rv", {31'd0, result_valid}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_dz", {31'd0, div_zero}, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;

    do_div("divu_100_7",   OP_DIVU, 32'd100,        32'd7,          33, 32'd14,         32'd2,          1'b0);
    do_div("div_m7_2",     OP_DIV,  32'hFFFFFFF9,   32'd2,          33, 32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0);
    do_div("div_7_m2",     OP_DIV,  32'd7,          32'hFFFFFFFE,   33, 32'hFFFFFFFD,   32'd1,          1'b0);
    do_div("div_5_0",      OP_DIV,  32'd5,          32'd0,          2,  32'd0,          32'd0,          1'b1);
    do_div("div_min_m1",   OP_DIV,  32'h80000000,   32'hFFFFFFFF,   33, 32'h80000000,   32'd0,          1'b0);
    do_div("divu_max_1",   OP_DIVU, 32'hFFFFFFFF,   32'd1,          33, 32'hFFFFFFFF,   32'd0,          1'b0);
    do_div("div_0_5",      OP_DIV,  32'd0,          32'd5,          33, 32'd0,          32'd0,          1'b0);
    do_div("divu_msb_3",   OP_DIVU, 32'h80000000,   32'd3,          33, 32'h2AAAAAAA,   32'd2,          1'b0);
    last_lo = 32'h2AAAAAAA;
    last_hi = 32'd2;

    // Flush partway through: cycle 10 carries annul, cycle 11 starts a new divide.
    alucontrol = OP_DIVU;
    a          = 32'd100;
    b          = 32'd7;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    alucontrol = OP_NOP;
    repeat (9) @(posedge clk);
    #1;
    annul = 1'b1;
    @(negedge clk);
    check("annul_c10_rv", {31'd0, result_valid}, 32'd0);
    @(posedge clk);
    #1;
    annul = 1'b0;
    #1;
    check("annul_c11_stall", {31'd0, stall}, 32'd0);
    check("annul_c11_rv", {31'd0, result_valid}, 32'd0);
    check("annul_hold_lo", lo, last_lo);
    check("annul_hold_hi", hi, last_hi);
    do_div("after_annul", OP_DIVU, 32'd1000, 32'd3, 33, 32'd333, 32'd1, 1'b0);

    // Non-divide opcode must not stall or start anything.
    alucontrol = OP_ADD;
    a          = 32'd9;
    b          = 32'd3;
    start      = 1'b1;
    @(negedge clk);
    check("add_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    start      = 1'b0;
    alucontrol = OP_NOP;
    @(negedge clk);
    check("add_idle_stall", {31'd0, stall}, 32'd0);
    check("add_idle_rv", {31'd0, result_valid}, 32'd0);
    check("add_lo_hold", lo, 32'd333);

    // Asynchronous reset in the middle of a divide.
    @(posedge clk);
    #1;
    alucontrol = OP_DIVU;
    a          = 32'd50;
    b          = 32'd6;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    alucontrol = OP_NOP;
    repeat (4) @(posedge clk);
    #1;
    check("mid_stall_before_rst", {31'd0, stall}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_rv", {31'd0, result_valid}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    do_div("after_reset", OP_DIVU, 32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
